// File: rtl/reg_file_sb.sv
// Register file with two read ports, one write port, hardwired-zero x0 and a
// per-register busy scoreboard (issue reserves, writeback releases).
module reg_file_sb #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int SYNC_READ     = 0,
    parameter int BYPASS        = 1,
    parameter int DEBUG_REG     = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] AD1,
    input  logic [ADDRESS_WIDTH-1:0] AD2,
    output logic [DATA_WIDTH-1:0]    RD1,
    output logic [DATA_WIDTH-1:0]    RD2,
    output logic                     RDY1,
    output logic                     RDY2,
    input  logic                     WE3,
    input  logic [ADDRESS_WIDTH-1:0] AD3,
    input  logic [DATA_WIDTH-1:0]    WD3,
    input  logic                     RSV_EN,
    input  logic [ADDRESS_WIDTH-1:0] RSV_AD,
    output logic [DATA_WIDTH-1:0]    a0,
    output logic [ADDRESS_WIDTH:0]   pending
);

    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = {ADDRESS_WIDTH{1'b0}};
    localparam logic [ADDRESS_WIDTH-1:0] DBG_IDX  = ADDRESS_WIDTH'(DEBUG_REG);

    function automatic logic [ADDRESS_WIDTH:0] popcount(input logic [DEPTH-1:0] bits);
        logic [ADDRESS_WIDTH:0] cnt;
        cnt = {(ADDRESS_WIDTH+1){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{ADDRESS_WIDTH{1'b0}}, bits[i]};
        end
        return cnt;
    endfunction

    logic [DATA_WIDTH-1:0]    mem_r [DEPTH];
    logic [DEPTH-1:0]         busy_r;
    logic [DEPTH-1:0]         busy_nxt_s;
    logic                     wr_fire_s;
    logic                     rsv_fire_s;
    logic [ADDRESS_WIDTH-1:0] rd_ad_s  [2];
    logic [DATA_WIDTH-1:0]    v_data_s [2];
    logic                     v_rdy_s  [2];

    assign wr_fire_s  = WE3 && (AD3 != ZERO_IDX);
    assign rsv_fire_s = RSV_EN && (RSV_AD != ZERO_IDX);
    assign rd_ad_s[0] = AD1;
    assign rd_ad_s[1] = AD2;

    // Scoreboard next state: writeback releases first so a same-index reservation wins.
    always_comb begin
        busy_nxt_s = busy_r;
        if (wr_fire_s) begin
            busy_nxt_s[AD3] = 1'b0;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        if (rsv_fire_s) begin
            busy_nxt_s[RSV_AD] = 1'b1;
        end else begin
            busy_nxt_s = busy_nxt_s;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Register storage and busy bits; x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            busy_r <= {DEPTH{1'b0}};
        end else begin
            if (wr_fire_s) begin
                mem_r[AD3] <= WD3;
            end
            busy_r <= busy_nxt_s;
        end
    end

    // Per-port read view: x0, then optional writeback forwarding, then storage.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            v_data_s[p] = {DATA_WIDTH{1'b0}};
            v_rdy_s[p]  = 1'b1;
            if (rd_ad_s[p] == ZERO_IDX) begin
                v_data_s[p] = {DATA_WIDTH{1'b0}};
                v_rdy_s[p]  = 1'b1;
            end else if ((BYPASS != 0) && wr_fire_s && (AD3 == rd_ad_s[p])) begin
                v_data_s[p] = WD3;
                v_rdy_s[p]  = 1'b1;
            end else begin
                v_data_s[p] = mem_r[rd_ad_s[p]];
                v_rdy_s[p]  = ~busy_r[rd_ad_s[p]];
            end
        end
    end

    generate
        if (SYNC_READ != 0) begin : g_sync_read
            logic [DATA_WIDTH-1:0] rd1_r;
            logic [DATA_WIDTH-1:0] rd2_r;
            logic                  rdy1_r;
            logic                  rdy2_r;

            // Registered read: operands appear the cycle after the address.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd1_r  <= {DATA_WIDTH{1'b0}};
                    rd2_r  <= {DATA_WIDTH{1'b0}};
                    rdy1_r <= 1'b1;
                    rdy2_r <= 1'b1;
                end else begin
                    rd1_r  <= v_data_s[0];
                    rd2_r  <= v_data_s[1];
                    rdy1_r <= v_rdy_s[0];
                    rdy2_r <= v_rdy_s[1];
                end
            end

            assign RD1  = rd1_r;
            assign RD2  = rd2_r;
            assign RDY1 = rdy1_r;
            assign RDY2 = rdy2_r;
        end else begin : g_comb_read
            assign RD1  = v_data_s[0];
            assign RD2  = v_data_s[1];
            assign RDY1 = v_rdy_s[0];
            assign RDY2 = v_rdy_s[1];
        end
    endgenerate

    assign a0      = mem_r[DBG_IDX];
    assign pending = popcount(busy_r);

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: three configurations share one stimulus
// stream and are checked against an array-based model of the register file.
module tb_reg_file_sb;

    logic        clk;
    logic        rst;
    logic [4:0]  AD1, AD2, AD3, RSV_AD;
    logic        WE3, RSV_EN;
    logic [31:0] WD3;

    logic [31:0] c_rd1, c_rd2, c_a0, n_rd1, n_rd2, n_a0, s_rd1, s_rd2, s_a0;
    logic        c_rdy1, c_rdy2, n_rdy1, n_rdy2, s_rdy1, s_rdy2;
    logic [5:0]  c_pend, n_pend, s_pend;

    reg_file_sb #(.SYNC_READ(0), .BYPASS(1), .DEBUG_REG(10)) u_comb (
        .clk(clk), .rst(rst), .AD1(AD1), .AD2(AD2), .RD1(c_rd1), .RD2(c_rd2),
        .RDY1(c_rdy1), .RDY2(c_rdy2), .WE3(WE3), .AD3(AD3), .WD3(WD3),
        .RSV_EN(RSV_EN), .RSV_AD(RSV_AD), .a0(c_a0), .pending(c_pend));

    reg_file_sb #(.SYNC_READ(0), .BYPASS(0), .DEBUG_REG(10)) u_nobyp (
        .clk(clk), .rst(rst), .AD1(AD1), .AD2(AD2), .RD1(n_rd1), .RD2(n_rd2),
        .RDY1(n_rdy1), .RDY2(n_rdy2), .WE3(WE3), .AD3(AD3), .WD3(WD3),
        .RSV_EN(RSV_EN), .RSV_AD(RSV_AD), .a0(n_a0), .pending(n_pend));

    reg_file_sb #(.SYNC_READ(1), .BYPASS(1), .DEBUG_REG(10)) u_sync (
        .clk(clk), .rst(rst), .AD1(AD1), .AD2(AD2), .RD1(s_rd1), .RD2(s_rd2),
        .RDY1(s_rdy1), .RDY2(s_rdy2), .WE3(WE3), .AD3(AD3), .WD3(WD3),
        .RSV_EN(RSV_EN), .RSV_AD(RSV_AD), .a0(s_a0), .pending(s_pend));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] d; logic r; } rv_t;
    typedef struct packed {
        rv_t c1, c2, n1, n2, s1, s2;
        logic [31:0] a0;
        logic [5:0]  pend;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_mem  [32];
    bit          m_busy [32];
    rv_t         sp1, sp2;
    int          checks   = 0;
    int          failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rv_t model_read(input logic [4:0] ad, input bit byp);
        rv_t v;
        if (ad == 5'd0) v = '{d: 32'd0, r: 1'b1};
        else if (byp && WE3 && AD3 == ad) v = '{d: WD3, r: 1'b1};
        else v = '{d: m_mem[ad], r: !m_busy[ad]};
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
        sp1 = '{d: 32'd0, r: 1'b1};
        sp2 = '{d: 32'd0, r: 1'b1};
    endtask

    // Apply inputs now, queue what every instance must show this cycle, then advance the model.
    task automatic drive_now(input logic we, input logic [4:0] ad3, input logic [31:0] wd,
                             input logic rsv, input logic [4:0] rad,
                             input logic [4:0] ad1, input logic [4:0] ad2);
        exp_t e;
        int   cnt;
        WE3 = we; AD3 = ad3; WD3 = wd; RSV_EN = rsv; RSV_AD = rad; AD1 = ad1; AD2 = ad2;
        e.c1 = model_read(ad1, 1'b1);
        e.c2 = model_read(ad2, 1'b1);
        e.n1 = model_read(ad1, 1'b0);
        e.n2 = model_read(ad2, 1'b0);
        e.s1 = sp1;
        e.s2 = sp2;
        e.a0 = m_mem[10];
        cnt = 0;
        for (int i = 0; i < 32; i++) cnt += int'(m_busy[i]);
        e.pend = 6'(cnt);
        exp_q.push_back(e);
        sp1 = e.c1;
        sp2 = e.c2;
        if (we && ad3 != 5'd0) begin
            m_mem[ad3]  = wd;
            m_busy[ad3] = 1'b0;
        end
        if (rsv && rad != 5'd0) m_busy[rad] = 1'b1;
    endtask

    task automatic drive(input logic we, input logic [4:0] ad3, input logic [31:0] wd,
                         input logic rsv, input logic [4:0] rad,
                         input logic [4:0] ad1, input logic [4:0] ad2);
        @(posedge clk);
        #1;
        drive_now(we, ad3, wd, rsv, rad, ad1, ad2);
    endtask

    // Half-cycle reset pulse between clock edges; effects must be visible at once.
    task automatic async_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_rd1", c_rd1, 32'd0);
        check("rst_pending", c_pend, 32'd0);
        check("rst_a0", c_a0, 32'd0);
        check("rst_sync_rd1", s_rd1, 32'd0);
        check("rst_sync_rdy1", s_rdy1, 32'd1);
        #1;
        rst = 1'b0;
        model_reset();
        drive_now(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, AD1, AD2);
    endtask

    // Monitor: every queued expectation is compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("comb_rd1", c_rd1, e.c1.d);   check("comb_rdy1", c_rdy1, e.c1.r);
            check("comb_rd2", c_rd2, e.c2.d);   check("comb_rdy2", c_rdy2, e.c2.r);
            check("nobyp_rd1", n_rd1, e.n1.d);  check("nobyp_rdy1", n_rdy1, e.n1.r);
            check("nobyp_rd2", n_rd2, e.n2.d);  check("nobyp_rdy2", n_rdy2, e.n2.r);
            check("sync_rd1", s_rd1, e.s1.d);   check("sync_rdy1", s_rdy1, e.s1.r);
            check("sync_rd2", s_rd2, e.s2.d);   check("sync_rdy2", s_rdy2, e.s2.r);
            check("a0", c_a0, e.a0);
            check("sync_a0", s_a0, e.a0);
            check("pending", c_pend, e.pend);
            check("nobyp_pending", n_pend, e.pend);
        end
    end

    function automatic logic [4:0] rand_ad();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        rst = 1'b1;
        WE3 = 1'b0; AD3 = 5'd0; WD3 = 32'd0; RSV_EN = 1'b0; RSV_AD = 5'd0; AD1 = 5'd0; AD2 = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        drive(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 5'd5, 5'd5);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        async_reset();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd5);

        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);

        drive(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 5'd7, 5'd7);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd7);

        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd3, 5'd3);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);
        drive(1'b1, 5'd3, 32'hAB, 1'b0, 5'd0, 5'd3, 5'd3);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd3, 5'd3);

        drive(1'b1, 5'd4, 32'h5, 1'b1, 5'd4, 5'd4, 5'd4);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
        drive(1'b1, 5'd4, 32'h1, 1'b0, 5'd0, 5'd4, 5'd0);
        drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 5'd4, 5'd6);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd6);

        drive(1'b1, 5'd10, 32'h99, 1'b0, 5'd0, 5'd0, 5'd0);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd10, 5'd10);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd10, 5'd10);

        for (int i = 0; i < 600; i++) begin
            if (i == 300) async_reset();
            drive(1'($urandom_range(0, 1)), rand_ad(), $urandom(),
                  1'($urandom_range(0, 2) == 0), rand_ad(), rand_ad(), rand_ad());
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the core's 3-port register file (two read ports, one write port).
- Adds asynchronous reset, hardwired-zero register 0, optional write-to-read bypass and selectable combinational or registered read.
- Adds a per-register busy scoreboard: issue reserves a destination, writeback releases it, and each read port reports whether its operand is ready.
- Sits between decode/issue and writeback of the pipelined CPU; the hazard unit stalls on the RDY outputs.

Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDRESS_WIDTH, 5, register index width; depth = 2**ADDRESS_WIDTH
- SYNC_READ, 0, 0 = combinational read; 1 = read data/ready registered (1-cycle latency)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding
- DEBUG_REG, 10, index driven onto a0 for testbench/display

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- AD1  input  ADDRESS_WIDTH  read port 1 index (rs1)
- AD2  input  ADDRESS_WIDTH  read port 2 index (rs2)
- RD1  output  DATA_WIDTH  read port 1 data
- RD2  output  DATA_WIDTH  read port 2 data
- RDY1  output  1  read port 1 operand valid (not pending)
- RDY2  output  1  read port 2 operand valid (not pending)
- WE3  input  1  writeback enable
- AD3  input  ADDRESS_WIDTH  writeback index (rd)
- WD3  input  DATA_WIDTH  writeback data
- RSV_EN  input  1  issue-time reservation of a destination
- RSV_AD  input  ADDRESS_WIDTH  index to reserve
- a0  output  DATA_WIDTH  contents of register DEBUG_REG (storage value, no bypass)
- pending  output  ADDRESS_WIDTH+1  number of busy registers

Behaviour:
- Reset is asynchronous, taking effect immediately on rst high, independent of clk:
  - all registers clear to 0 and all busy bits clear to 0; a0 = 0; pending = 0.
  - With SYNC_READ=1: RD1/RD2 = 0 and RDY1/RDY2 = 1.
  - Reset asserted mid-operation discards any write or reservation in that cycle.
- Register 0:
  - Reads always return 0 with RDY = 1.
  - A write with AD3 = 0 is ignored.
  - A reservation with RSV_AD = 0 is ignored; busy[0] is never set.
- Write: at a rising edge with WE3 = 1 and AD3 != 0, mem[AD3] <= WD3 and busy[AD3] <= 0.
- Reserve: at a rising edge with RSV_EN = 1 and RSV_AD != 0, busy[RSV_AD] <= 1.
- Write and reserve to the same index in the same cycle: the data is written and busy stays 1 (a newer producer owns the register).
- Write and reserve to different indices in the same cycle: both take effect.
- Reserving an already-busy register leaves busy at 1. The scoreboard holds one bit per register, not a count.
- Combinational read value V(n) for port n:
  - ADn = 0: data 0, ready 1.
  - Else, if BYPASS = 1, WE3 = 1 and AD3 = ADn: data WD3, ready 1.
  - Otherwise: data mem[ADn], ready = ~busy[ADn].
- SYNC_READ = 0: RDn/RDYn = V(n), valid in the same cycle the address is applied.
- SYNC_READ = 1: RDn/RDYn <= V(n) at each rising edge, valid the cycle after the address.
  - With BYPASS = 0, a same-cycle write to the same index returns old data and the old ready state (read-before-write).
- a0 = mem[DEBUG_REG] combinationally. It updates the cycle after the write edge and is never bypassed.
- pending = population count of the busy bits; maximum is 2**ADDRESS_WIDTH - 1.
- Both read ports are fully independent and may address the same index.

Test Plan:
- Reset: write 0x12345678 to x5, assert rst for half a cycle with no clk edge -> RD1 (AD1 = 5) = 0 immediately, pending = 0, a0 = 0.
- x0: WE3 = 1, AD3 = 0, WD3 = 0xFFFFFFFF, RSV_EN = 1, RSV_AD = 0 -> RD1 (AD1 = 0) = 0, RDY1 = 1, pending = 0.
- Bypass (SYNC_READ = 0, BYPASS = 1): x7 = 0x11. Then WE3 = 1, AD3 = 7, WD3 = 0x22 with AD1 = AD2 = 7 -> RD1 = RD2 = 0x22 in the same cycle. With BYPASS = 0 -> 0x11 until the edge, then 0x22.
- Scoreboard: reserve x3 -> next cycle RDY1 (AD1 = 3) = 0, pending = 1. Write x3 = 0xAB -> RDY1 = 1, RD1 = 0xAB, pending = 0.
- Simultaneous events: reserve x4 and write x4 = 0x5 in the same cycle -> mem[4] = 5, RDY = 0, pending = 1. Reserve x4 while writing x6 -> both take effect.
- SYNC_READ = 1, DEBUG_REG = 10: write x10 = 0x99 -> a0 = 0x99 after the edge. Apply AD1 = 10 -> RD1 = 0x99 one cycle later and holds its prior value during the address cycle.
